divider_8: RTL and testbench

Sequential unsigned restoring divider, the inverse of the datapath's ripple-carry adder path. Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. Subtraction is done by a ripple-carry subtractor built from the team's full-adder cells (A + ~B + 1). It sits beside the shift-add multiplier in the 8-bit logic processor, started by the same Run control.

---
 rtl/divider_pkg.sv | 17 +
 rtl/divider_8_if.sv | 40 ++++
 rtl/ripple_subtractor.sv | 27 ++
 rtl/divider_8.sv | 118 +++++++++++
 tb/tb_divider_8.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Imported by the divider interface, top and subtractor.
package divider_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divider_8_if.sv
// Start/operand/result bundle between the processor control and the divider.
// Master drives Run and operands; slave returns results and status.
interface divider_8_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             Run;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Run,
    output Dividend,
    output Divisor,
    input  Quotient,
    input  Remainder,
    input  Busy,
    input  Done,
    input  DivByZero
  );

  modport slave (
    input  Run,
    input  Dividend,
    input  Divisor,
    output Quotient,
    output Remainder,
    output Busy,
    output Done,
    output DivByZero
  );

endinterface

// File: rtl/ripple_subtractor.sv
// A - B as a full-adder ripple chain: A + ~B + 1.
// carry_out = 1 means no borrow (A >= B).
module ripple_subtractor
  import divider_pkg::*;
#(
  parameter int W = DEF_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         carry_out
);

  logic [W:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic bn;
    assign bn        = ~b[i];
    assign diff[i]   = a[i] ^ bn ^ c[i];
    assign c[i+1]    = (a[i] & bn) | (c[i] & (a[i] ^ bn));
  end

  assign carry_out = c[W];

endmodule

// File: rtl/divider_8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Results are registered and held until the next completion.
module divider_8
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  divider_8_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t;
  logic             nb;

  assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  ripple_subtractor #(
    .W(WIDTH + 1)
  ) u_sub (
    .a        (r_sh),
    .b        ({1'b0, d_q}),
    .diff     (t),
    .carry_out(nb)
  );

  // The remainder MSB is only headroom for the shifted partial remainder.
  logic unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Run) begin
          r_d     = '0;
          q_d     = bus.Dividend;
          d_d     = bus.Divisor;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        r_d = nb ? t : r_sh;
        q_d = {q_q[WIDTH-2:0], nb};
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dbz_d   = (d_q == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!bus.Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_divider_8.sv
// Randomised and directed checks of divider_8 against an arithmetic model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_divider_8;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  logic [7:0] prev_q;
  logic [7:0] prev_r;

  divider_8_if #(.WIDTH(8)) bus ();

  divider_8 #(
    .WIDTH(8)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input bit perturb, input int hold);
    logic [7:0] eq;
    logic [7:0] er;
    logic       ez;
    int         busy_n;
    bit         seen;
    if (b == 8'd0) begin
      eq = 8'hFF;
      er = a;
      ez = 1'b1;
    end else begin
      eq = a / b;
      er = a % b;
      ez = 1'b0;
    end
    @(negedge Clk);
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Run      = 1'b1;
    @(negedge Clk);
    chk("busy_start", bus.Busy, 1);
    busy_n = 0;
    seen   = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.Done) begin
        seen = 1;
      end else begin
        if (bus.Busy) busy_n++;
        chk("hold_q", bus.Quotient, prev_q);
        chk("hold_r", bus.Remainder, prev_r);
        if (perturb) begin
          bus.Run      = 1'($urandom);
          bus.Dividend = 8'($urandom);
          bus.Divisor  = 8'($urandom);
        end else begin
          bus.Run = 1'b0;
        end
        @(negedge Clk);
      end
    end
    chk("timeout", seen, 1);
    chk("busy_cycles", busy_n, 8);
    chk("busy_done", bus.Busy, 0);
    chk("quotient", bus.Quotient, eq);
    chk("remainder", bus.Remainder, er);
    chk("divbyzero", bus.DivByZero, ez);
    prev_q = eq;
    prev_r = er;
    if (hold > 0) begin
      bus.Run = 1'b1;
      repeat (hold) @(negedge Clk);
      chk("hold_done", bus.Done, 1);
      chk("hold_busy", bus.Busy, 0);
      chk("hold_quot", bus.Quotient, eq);
    end
    bus.Run = 1'b0;
    @(negedge Clk);
    chk("done_fall", bus.Done, 0);
    chk("idle_busy", bus.Busy, 0);
  endtask

  task automatic reset_mid_calc(input logic [7:0] a, input logic [7:0] b);
    @(negedge Clk);
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Run      = 1'b1;
    @(negedge Clk);
    bus.Run = 1'b0;
    repeat (3) @(negedge Clk);
    chk("pre_rst_busy", bus.Busy, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_quot", bus.Quotient, 0);
    chk("rst_rem", bus.Remainder, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_dbz", bus.DivByZero, 0);
    prev_q = 8'd0;
    prev_r = 8'd0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    prev_q       = 8'd0;
    prev_r       = 8'd0;
    Reset        = 1'b1;
    bus.Run      = 1'b0;
    bus.Dividend = 8'd0;
    bus.Divisor  = 8'd0;
    repeat (2) @(negedge Clk);
    chk("init_quot", bus.Quotient, 0);
    chk("init_rem", bus.Remainder, 0);
    chk("init_busy", bus.Busy, 0);
    chk("init_done", bus.Done, 0);
    chk("init_dbz", bus.DivByZero, 0);
    Reset = 1'b0;

    run_div(8'd200, 8'd7, 0, 0);
    run_div(8'd255, 8'd1, 0, 0);
    run_div(8'd5, 8'd9, 0, 0);
    run_div(8'd255, 8'd255, 0, 0);
    run_div(8'd0, 8'd3, 0, 0);
    run_div(8'h80, 8'd0, 0, 0);
    run_div(8'd10, 8'd3, 0, 0);
    run_div(8'd77, 8'd6, 0, 5);
    run_div(8'd123, 8'd11, 1, 0);
    reset_mid_calc(8'd200, 8'd7);
    run_div(8'd200, 8'd7, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      run_div(a, b, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
